// File: rtl/triple_window_pkg.sv
// Shared types for the triple_window front-end and the min/max/mid comparator it feeds.
package triple_window_pkg;

   localparam int SAMPLE_W = 7;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } fill_e;

   // a = oldest, b = middle, c = newest; also the comparator's input bundle
   typedef struct packed {
      logic [SAMPLE_W-1:0] a;
      logic [SAMPLE_W-1:0] b;
      logic [SAMPLE_W-1:0] c;
   } triple_t;

endpackage

// File: rtl/triple_window_triple_reg.sv
// Output register slice: holds one triple with a valid/ready handshake.
module triple_reg
   import triple_window_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        load,
   input  logic [$bits(triple_t)-1:0]  next,
   input  logic                        out_ready,
   output logic                        out_valid,
   output logic [$bits(triple_t)-1:0]  triple,
   output logic                        free
);

   logic    valid_reg;
   triple_t data_reg;

   assign free      = !valid_reg || out_ready;
   assign out_valid = valid_reg;
   assign triple    = data_reg;

   // load is only raised while free, so a load also covers the consume of the old triple
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         data_reg  <= '0;
      end else if (load) begin
         valid_reg <= 1'b1;
         data_reg  <= next;
      end else if (out_ready) begin
         valid_reg <= 1'b0;
      end
   end

endmodule

// File: rtl/triple_window.sv
// Groups a sample stream into windows of three (sliding or block) and presents each as a registered triple.
module triple_window
   import triple_window_pkg::*;
#(
   parameter int W     = SAMPLE_W,
   parameter bit SLIDE = 1'b1
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         flush,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_a,
   output logic [W-1:0] out_b,
   output logic [W-1:0] out_c,
   output logic [1:0]   fill
);

   logic [W-1:0] h0_reg;
   logic [W-1:0] h1_reg;
   fill_e        fill_reg;
   logic         free;
   logic         accept;
   logic         load;
   triple_t      next_triple;
   triple_t      held;

   assign in_ready = rst_n && !flush && free;
   assign accept   = in_valid && in_ready;
   assign load     = accept && (fill_reg == TWO);

   assign next_triple.a = h0_reg;
   assign next_triple.b = h1_reg;
   assign next_triple.c = in_data;

   // History always shifts on accept; in block mode it is don't-care once fill returns to EMPTY
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fill_reg <= EMPTY;
         h0_reg   <= '0;
         h1_reg   <= '0;
      end else if (flush) begin
         fill_reg <= EMPTY;
      end else if (accept) begin
         h0_reg <= h1_reg;
         h1_reg <= in_data;
         case (fill_reg)
            EMPTY:   fill_reg <= ONE;
            ONE:     fill_reg <= TWO;
            default: fill_reg <= SLIDE ? TWO : EMPTY;
         endcase
      end
   end

   triple_reg u_triple_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .next      (next_triple),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .triple    (held),
      .free      (free)
   );

   assign out_a = held.a;
   assign out_b = held.b;
   assign out_c = held.c;
   assign fill  = fill_reg;

endmodule

// File: tb/tb_triple_window.sv
// Drives a SLIDE=1 and a SLIDE=0 instance with shared stimulus; checks directed scenarios and a random run.
module tb_triple_window;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [6:0] in_data = '0;
   logic       flush = 1'b0;
   logic       out_ready = 1'b0;

   logic       ir_o [2];
   logic       ov_o [2];
   logic [6:0] oa [2];
   logic [6:0] ob [2];
   logic [6:0] oc [2];
   logic [1:0] fill_o [2];

   int total = 0;
   int bad = 0;

   // reference model, index = SLIDE value
   logic [6:0] mh [2][3];
   int         mcnt [2];
   logic       mov [2];
   logic [6:0] ma [2];
   logic [6:0] mb [2];
   logic [6:0] mc [2];
   logic       ir_exp [2];
   logic       ir_obs [2];

   always #5 clk = ~clk;

   triple_window #(.W(7), .SLIDE(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_o[1]), .in_data(in_data),
      .flush(flush), .out_valid(ov_o[1]), .out_ready(out_ready),
      .out_a(oa[1]), .out_b(ob[1]), .out_c(oc[1]), .fill(fill_o[1])
   );

   triple_window #(.W(7), .SLIDE(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_o[0]), .in_data(in_data),
      .flush(flush), .out_valid(ov_o[0]), .out_ready(out_ready),
      .out_a(oa[0]), .out_b(ob[0]), .out_c(oc[0]), .fill(fill_o[0])
   );

   // One clock: drive at negedge, capture in_ready, advance the model, return just after posedge
   task automatic cycle(input logic v, input logic [6:0] d, input logic fl, input logic ordy, input logic rn);
      logic ir;
      logic loaded;
      @(negedge clk);
      rst_n = rn; in_valid = v; in_data = d; flush = fl; out_ready = ordy;
      #1;
      for (int s = 0; s < 2; s++) begin
         ir_obs[s] = ir_o[s];
         ir = rn && !fl && (!mov[s] || ordy);
         ir_exp[s] = ir;
         loaded = 1'b0;
         if (!rn) begin
            mcnt[s] = 0; mov[s] = 1'b0; ma[s] = '0; mb[s] = '0; mc[s] = '0;
         end else begin
            if (fl) begin
               mcnt[s] = 0;
            end else if (v && ir) begin
               mh[s][mcnt[s]] = d;
               mcnt[s]++;
               if (mcnt[s] == 3) begin
                  ma[s] = mh[s][0]; mb[s] = mh[s][1]; mc[s] = mh[s][2];
                  loaded = 1'b1;
                  if (s == 1) begin
                     mh[s][0] = mh[s][1]; mh[s][1] = mh[s][2]; mcnt[s] = 2;
                  end else begin
                     mcnt[s] = 0;
                  end
               end
            end
            if (loaded) mov[s] = 1'b1;
            else if (mov[s] && ordy) mov[s] = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cycle(1'b1, 7'd33, 1'b0, 1'b1, 1'b0);
      for (int s = 0; s < 2; s++) begin
         total += 4;
         if (ir_obs[s] !== 1'b0) begin bad++; $display("FAIL reset_in_ready s=%0d got=%b exp=0", s, ir_obs[s]); end
         if (ov_o[s] !== 1'b0) begin bad++; $display("FAIL reset_out_valid s=%0d got=%b exp=0", s, ov_o[s]); end
         if (fill_o[s] !== 2'd0) begin bad++; $display("FAIL reset_fill s=%0d got=%0d exp=0", s, fill_o[s]); end
         if ({oa[s], ob[s], oc[s]} !== 21'd0) begin
            bad++; $display("FAIL reset_outs s=%0d got=(%0d,%0d,%0d) exp=(0,0,0)", s, oa[s], ob[s], oc[s]);
         end
      end
   endtask

   task automatic test_slide();
      logic [6:0] seq [4];
      logic [1:0] efill [4];
      logic [20:0] etrip [4];
      seq = '{7'd5, 7'd9, 7'd2, 7'd7};
      efill = '{2'd1, 2'd2, 2'd2, 2'd2};
      etrip = '{21'd0, 21'd0, {7'd5, 7'd9, 7'd2}, {7'd9, 7'd2, 7'd7}};
      cycle(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, seq[i], 1'b0, 1'b1, 1'b1);
         total++;
         if (fill_o[1] !== efill[i]) begin bad++; $display("FAIL slide_fill%0d got=%0d exp=%0d", i, fill_o[1], efill[i]); end
         total++;
         if (ov_o[1] !== (i >= 2)) begin bad++; $display("FAIL slide_valid%0d got=%b exp=%b", i, ov_o[1], (i >= 2)); end
         if (i >= 2) begin
            total++;
            if ({oa[1], ob[1], oc[1]} !== etrip[i]) begin
               bad++; $display("FAIL slide_triple%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)", i, oa[1], ob[1], oc[1],
                               etrip[i][20:14], etrip[i][13:7], etrip[i][6:0]);
            end
         end
      end
      cycle(1'b0, 7'd0, 1'b0, 1'b1, 1'b1);
      total++;
      if (ov_o[1] !== 1'b0) begin bad++; $display("FAIL slide_drain got=%b exp=0", ov_o[1]); end
   endtask

   task automatic test_block();
      int ntrip;
      ntrip = 0;
      cycle(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         cycle(1'b1, 7'(i), 1'b0, 1'b1, 1'b1);
         if (ov_o[0] === 1'b1) ntrip++;
         if (i == 3 || i == 6) begin
            total += 2;
            if (fill_o[0] !== 2'd0) begin bad++; $display("FAIL block_fill%0d got=%0d exp=0", i, fill_o[0]); end
            if ({oa[0], ob[0], oc[0]} !== {7'(i - 2), 7'(i - 1), 7'(i)}) begin
               bad++; $display("FAIL block_triple%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)", i, oa[0], ob[0], oc[0], i - 2, i - 1, i);
            end
         end
      end
      cycle(1'b0, 7'd0, 1'b0, 1'b1, 1'b1);
      if (ov_o[0] === 1'b1) ntrip++;
      total++;
      if (ntrip != 2) begin bad++; $display("FAIL block_count got=%0d exp=2", ntrip); end
   endtask

   task automatic test_backpressure();
      cycle(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 3; i++) cycle(1'b1, 7'(i), 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, 7'd100, 1'b0, 1'b0, 1'b1);
         total += 3;
         if (ir_obs[1] !== 1'b0) begin bad++; $display("FAIL bp_in_ready%0d got=%b exp=0", k, ir_obs[1]); end
         if (ov_o[1] !== 1'b1) begin bad++; $display("FAIL bp_valid%0d got=%b exp=1", k, ov_o[1]); end
         if ({oa[1], ob[1], oc[1]} !== {7'd1, 7'd2, 7'd3}) begin
            bad++; $display("FAIL bp_hold%0d got=(%0d,%0d,%0d) exp=(1,2,3)", k, oa[1], ob[1], oc[1]);
         end
      end
      cycle(1'b1, 7'd100, 1'b0, 1'b1, 1'b1);
      total += 2;
      if (ir_obs[1] !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", ir_obs[1]); end
      if (ov_o[1] !== 1'b1 || {oa[1], ob[1], oc[1]} !== {7'd2, 7'd3, 7'd100}) begin
         bad++; $display("FAIL bp_next got=v%b (%0d,%0d,%0d) exp=v1 (2,3,100)", ov_o[1], oa[1], ob[1], oc[1]);
      end
      cycle(1'b0, 7'd0, 1'b0, 1'b1, 1'b1);
      total++;
      if (ov_o[1] !== 1'b0) begin bad++; $display("FAIL bp_no_dup got=%b exp=0", ov_o[1]); end
   endtask

   task automatic test_flush();
      logic early;
      early = 1'b0;
      cycle(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 7'd10, 1'b0, 1'b1, 1'b1);
      cycle(1'b1, 7'd20, 1'b0, 1'b1, 1'b1);
      cycle(1'b1, 7'd99, 1'b1, 1'b1, 1'b1);
      total += 3;
      if (ir_obs[1] !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", ir_obs[1]); end
      if (fill_o[1] !== 2'd0) begin bad++; $display("FAIL flush_fill1 got=%0d exp=0", fill_o[1]); end
      if (fill_o[0] !== 2'd0) begin bad++; $display("FAIL flush_fill0 got=%0d exp=0", fill_o[0]); end
      cycle(1'b1, 7'd30, 1'b0, 1'b1, 1'b1);
      if (ov_o[1] !== 1'b0 || ov_o[0] !== 1'b0) early = 1'b1;
      cycle(1'b1, 7'd40, 1'b0, 1'b1, 1'b1);
      if (ov_o[1] !== 1'b0 || ov_o[0] !== 1'b0) early = 1'b1;
      total++;
      if (early) begin bad++; $display("FAIL flush_early_triple got=1 exp=0"); end
      cycle(1'b1, 7'd50, 1'b0, 1'b1, 1'b1);
      for (int s = 0; s < 2; s++) begin
         total++;
         if (ov_o[s] !== 1'b1 || {oa[s], ob[s], oc[s]} !== {7'd30, 7'd40, 7'd50}) begin
            bad++; $display("FAIL flush_triple s=%0d got=v%b (%0d,%0d,%0d) exp=v1 (30,40,50)", s, ov_o[s], oa[s], ob[s], oc[s]);
         end
      end
   endtask

   task automatic test_boundary();
      logic [6:0] mn, mx, md;
      cycle(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, 7'd0, 1'b0, 1'b1, 1'b1);
      cycle(1'b1, 7'd127, 1'b0, 1'b1, 1'b1);
      cycle(1'b1, 7'd127, 1'b0, 1'b1, 1'b1);
      total++;
      if ({oa[1], ob[1], oc[1]} !== {7'd0, 7'd127, 7'd127}) begin
         bad++; $display("FAIL bound_triple got=(%0d,%0d,%0d) exp=(0,127,127)", oa[1], ob[1], oc[1]);
      end
      mn = oa[1]; if (ob[1] < mn) mn = ob[1]; if (oc[1] < mn) mn = oc[1];
      mx = oa[1]; if (ob[1] > mx) mx = ob[1]; if (oc[1] > mx) mx = oc[1];
      md = 7'(int'(oa[1]) + int'(ob[1]) + int'(oc[1]) - int'(mn) - int'(mx));
      total++;
      if (mn !== 7'd0 || mx !== 7'd127 || md !== 7'd127) begin
         bad++; $display("FAIL bound_cmp got=min%0d max%0d mid%0d exp=min0 max127 mid127", mn, mx, md);
      end
   endtask

   task automatic test_reset_mid();
      cycle(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 3; i++) cycle(1'b1, 7'(i + 40), 1'b0, 1'b0, 1'b1);
      total++;
      if (ov_o[1] !== 1'b1 || fill_o[1] !== 2'd2) begin
         bad++; $display("FAIL rmid_pre got=v%b fill%0d exp=v1 fill2", ov_o[1], fill_o[1]);
      end
      cycle(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
      total++;
      if (ov_o[1] !== 1'b0 || fill_o[1] !== 2'd0 || {oa[1], ob[1], oc[1]} !== 21'd0) begin
         bad++; $display("FAIL rmid_clear got=v%b fill%0d (%0d,%0d,%0d) exp=v0 fill0 (0,0,0)", ov_o[1], fill_o[1], oa[1], ob[1], oc[1]);
      end
      for (int i = 7; i <= 9; i++) cycle(1'b1, 7'(i), 1'b0, 1'b1, 1'b1);
      total++;
      if (ov_o[1] !== 1'b1 || {oa[1], ob[1], oc[1]} !== {7'd7, 7'd8, 7'd9}) begin
         bad++; $display("FAIL rmid_fresh got=v%b (%0d,%0d,%0d) exp=v1 (7,8,9)", ov_o[1], oa[1], ob[1], oc[1]);
      end
   endtask

   task automatic test_random();
      cycle(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
      for (int n = 0; n < 1500; n++) begin
         cycle(1'($urandom_range(0, 3) != 0), 7'($urandom), 1'($urandom_range(0, 15) == 0),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) != 0));
         for (int s = 0; s < 2; s++) begin
            total += 4;
            if (ir_obs[s] !== ir_exp[s]) begin
               bad++; $display("FAIL rnd_in_ready n=%0d s=%0d got=%b exp=%b", n, s, ir_obs[s], ir_exp[s]);
            end
            if (ov_o[s] !== mov[s]) begin
               bad++; $display("FAIL rnd_valid n=%0d s=%0d got=%b exp=%b", n, s, ov_o[s], mov[s]);
            end
            if (fill_o[s] !== 2'(mcnt[s])) begin
               bad++; $display("FAIL rnd_fill n=%0d s=%0d got=%0d exp=%0d", n, s, fill_o[s], mcnt[s]);
            end
            if ({oa[s], ob[s], oc[s]} !== {ma[s], mb[s], mc[s]}) begin
               bad++; $display("FAIL rnd_triple n=%0d s=%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)",
                               n, s, oa[s], ob[s], oc[s], ma[s], mb[s], mc[s]);
            end
         end
      end
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         mcnt[s] = 0; mov[s] = 1'b0; ma[s] = '0; mb[s] = '0; mc[s] = '0;
      end
      test_reset();
      test_slide();
      test_block();
      test_backpressure();
      test_flush();
      test_boundary();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
